mem_stage_mmio: RTL
===================

MEM_STAGE_MMIO -- requirements
Module: mem_stage_mmio

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 256, data RAM depth in 32-bit words (power of two).
REQ-002 SHALL have ports:
  clk  in  1  single clock; all state updates on rising edge
  reset  in  1  synchronous, active-high
  i_mem_read  in  1  load in MEM stage this cycle
  i_mem_write  in  1  store in MEM stage this cycle
  i_addr  in  32  byte address (ALU result from EX/MEM)
  i_write_data  in  32  store data (rt value)
  o_read_data  out  32  load data, combinational, feeds MEM/WB i_mem_read_data
  o_leds  out  8  LED register
  o_digits  out  12  7-seg register: [11:8] anode select, [7:0] segments
  o_irq  out  1  timer interrupt request
  o_addr_err  out  1  misaligned/unmapped access flag, combinational
REQ-003 Reset is synchronous and active-high; one clock, clk.

Function
REQ-004 Address map, word-aligned only:
  0x0000_0000 to 4*RAM_WORDS-4: data RAM, index i_addr[log2(RAM_WORDS)+1:2]
  0x4000_0000 TH: timer reload, R/W
  0x4000_0004 TL: timer count, R/W
  0x4000_0008 TCON[2:0]: bit0 enable, bit1 irq enable, bit2 irq status; R/W, upper bits read 0
  0x4000_000C LEDs[7:0], R/W
  0x4000_0010 digits[11:0], R/W
  0x4000_0014 systick: free-running cycle counter, read-only
REQ-005 Reads SHALL be combinational: o_read_data valid same cycle as i_mem_read=1; 0 when i_mem_read=0.
REQ-006 Writes SHALL take effect on the rising edge when i_mem_write=1; zero extra latency.
REQ-007 Read and write to same address in same cycle: o_read_data SHALL return the pre-write value.
REQ-008 i_addr[1:0]!=0, or address outside map: o_addr_err=1 when i_mem_read or i_mem_write is 1; write SHALL be ignored; read SHALL return 0.
REQ-009 Writes to systick SHALL be ignored and raise no error.
REQ-010 Timer, when TCON[0]=1, each cycle: if TL=0xFFFF_FFFF then TL<=TH and TCON[2]<=1 if TCON[1]=1; else TL<=TL+1. TCON[0]=0 holds TL.
REQ-011 A software write to TL in the same cycle as a timer update SHALL win (TL takes written value).
REQ-012 A software write to TCON in the same cycle as an overflow SHALL apply bits [1:0] from the write, and bit2 SHALL end at 1 (overflow set beats software clear).
REQ-013 o_irq SHALL equal TCON[1] AND TCON[2], registered bits only, no combinational path from inputs.
REQ-014 systick SHALL increment by 1 every cycle, wrapping 0xFFFF_FFFF to 0, independent of TCON.
REQ-015 i_mem_read and i_mem_write both 1 SHALL perform both per REQ-007.

Reset
REQ-016 On reset: TH=0, TL=0, TCON=0, LEDs=0, digits=0, systick=0, so o_irq=0, o_leds=0, o_digits=0.
REQ-017 RAM contents SHALL NOT be cleared by reset.
REQ-018 Reset SHALL override a same-cycle write and a same-cycle timer update.
REQ-019 First cycle after reset deasserts, systick reads 0, then increments.

Verification
REQ-020 Write 0xDEADBEEF to 0x0000_0010, read 0x0000_0010 next cycle -> o_read_data=0xDEADBEEF, o_addr_err=0.
REQ-021 Write to 0x0000_0012 and read 0x5000_0000 -> o_addr_err=1, RAM word 0x10 unchanged, read data 0.
REQ-022 TH=0xFFFF_FFFD, TL=0xFFFF_FFFE, TCON=3 -> TL goes FFFF_FFFF, then FFFF_FFFD; TCON[2]=1 and o_irq=1 on that edge.
REQ-023 Write TCON=3 in the overflow cycle -> TCON reads 7, o_irq stays 1; next cycle write TCON=3 with no overflow -> o_irq=0.
REQ-024 Assert reset with TCON=7 while writing LEDs=0xFF -> o_leds=0, o_irq=0, systick=0, RAM word 0x10 still 0xDEADBEEF.
REQ-025 Read and write 0x4000_000C same cycle, old 0x12, new 0x34 -> o_read_data=0x12, next cycle reads 0x34.

Source files
------------

// File: rtl/mem_stage_mmio.sv
// MEM-stage data memory with memory-mapped timer, LED, 7-segment and systick registers.
// Loads and the address-error flag are combinational; stores commit on the rising clock edge.
module mem_stage_mmio #(
  parameter int RAM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_write_data,
  output logic [31:0] o_read_data,
  output logic [7:0]  o_leds,
  output logic [11:0] o_digits,
  output logic        o_irq,
  output logic        o_addr_err
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0]   ram_q [RAM_WORDS];
  logic [31:0]   th_q, th_d;
  logic [31:0]   tl_q, tl_d;
  logic [2:0]    tcon_q, tcon_d;
  logic [7:0]    leds_q, leds_d;
  logic [11:0]   digits_q, digits_d;
  logic [31:0]   systick_q, systick_d;

  logic          ram_hit_s;
  logic          mmio_hit_s;
  logic          ram_we_s;
  logic          mmio_we_s;
  logic          ovf_s;
  logic [AW-1:0] ram_idx_s;
  logic [31:0]   rdata_s;

  // Address decode and access-error flag
  always_comb begin
    ram_idx_s  = i_addr[AW+1:2];
    ram_hit_s  = (i_addr[1:0] == 2'b00) && ((i_addr >> (AW + 2)) == 32'd0);
    mmio_hit_s = (i_addr[1:0] == 2'b00) && (i_addr[31:5] == 27'h200_0000) &&
                 (i_addr[4:2] <= 3'd5);
    ram_we_s   = i_mem_write & ram_hit_s & ~reset;
    mmio_we_s  = i_mem_write & mmio_hit_s;
    o_addr_err = (i_mem_read | i_mem_write) & ~(ram_hit_s | mmio_hit_s);
  end

  // Load mux; sources are all registered so a same-cycle store is never visible here
  always_comb begin
    rdata_s = 32'd0;
    if (i_mem_read && ram_hit_s) begin
      rdata_s = ram_q[ram_idx_s];
    end else if (i_mem_read && mmio_hit_s) begin
      case (i_addr[4:2])
        3'd0:    rdata_s = th_q;
        3'd1:    rdata_s = tl_q;
        3'd2:    rdata_s = {29'd0, tcon_q};
        3'd3:    rdata_s = {24'd0, leds_q};
        3'd4:    rdata_s = {20'd0, digits_q};
        3'd5:    rdata_s = systick_q;
        default: rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
    o_read_data = rdata_s;
  end

  // Next state: timer update first, then software stores override it
  always_comb begin
    th_d      = th_q;
    leds_d    = leds_q;
    digits_d  = digits_q;
    systick_d = systick_q + 32'd1;
    ovf_s     = tcon_q[0] && (tl_q == 32'hFFFF_FFFF);
    if (ovf_s) begin
      tl_d = th_q;
    end else if (tcon_q[0]) begin
      tl_d = tl_q + 32'd1;
    end else begin
      tl_d = tl_q;
    end
    tcon_d = {tcon_q[2] | (ovf_s & tcon_q[1]), tcon_q[1:0]};
    if (mmio_we_s) begin
      case (i_addr[4:2])
        3'd0:    th_d     = i_write_data;
        3'd1:    tl_d     = i_write_data;
        // an overflow in this same cycle still leaves the status bit set
        3'd2:    tcon_d   = {i_write_data[2] | (ovf_s & tcon_q[1]), i_write_data[1:0]};
        3'd3:    leds_d   = i_write_data[7:0];
        3'd4:    digits_d = i_write_data[11:0];
        default: th_d     = th_q;
      endcase
    end else begin
      th_d = th_q;
    end
  end

  // Register file state with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      th_q      <= 32'd0;
      tl_q      <= 32'd0;
      tcon_q    <= 3'd0;
      leds_q    <= 8'd0;
      digits_q  <= 12'd0;
      systick_q <= 32'd0;
    end else begin
      th_q      <= th_d;
      tl_q      <= tl_d;
      tcon_q    <= tcon_d;
      leds_q    <= leds_d;
      digits_q  <= digits_d;
      systick_q <= systick_d;
    end
  end

  // Data RAM keeps its contents across reset
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      ram_q[ram_idx_s] <= i_write_data;
    end
  end

  assign o_leds   = leds_q;
  assign o_digits = digits_q;
  assign o_irq    = tcon_q[1] & tcon_q[2];

endmodule
